mp_csa_accumulator: RTL and testbench

//  Parametrised multi-precision carry-save accumulator for the Montgomery datapath.

---
 rtl/mp_pkg.sv | 21 ++
 rtl/mp_chunk_adder.sv | 19 +
 rtl/mp_csa_accumulator.sv | 175 +++++++++++++++++
 tb/tb_mp_csa_accumulator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared encodings for the multi-precision carry-save accumulator.
// Command opcodes, FSM states and the chunk-count helper.
package mp_pkg;

   localparam logic [1:0] MP_OP_ACC         = 2'b00;
   localparam logic [1:0] MP_OP_ACC_SHR     = 2'b01;
   localparam logic [1:0] MP_OP_RESOLVE     = 2'b10;
   localparam logic [1:0] MP_OP_RESOLVE_SUB = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RES  = 2'b01,
      ST_SUB  = 2'b10,
      ST_DONE = 2'b11
   } mp_state_t;

   function automatic int mp_nchunk(input int width, input int chunk);
      return (width + chunk - 1) / chunk;
   endfunction

endpackage

// File: rtl/mp_chunk_adder.sv
// Narrow resolution adder: a + (inv_b ? ~b : b) + cin, combinational.
// Time-multiplexed over the chunks by the accumulator; no flow control of its own.
module mp_chunk_adder #(
   parameter int W = 103
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   input  logic         inv_b,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W-1:0] b_eff;

   assign b_eff     = inv_b ? ~b : b;
   assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mp_csa_accumulator.sv
// Carry-save accumulator: ACC/ACC_SHR in 1 cycle, RESOLVE in NCHUNK+1, RESOLVE_SUB in 2*NCHUNK+1.
// Commands accepted only in IDLE; result held in DONE until res_ready.
module mp_csa_accumulator
   import mp_pkg::*;
#(
   parameter int WIDTH = 514,
   parameter int CHUNK = 103
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] in_a,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_borrow,
   output logic             lsb
);

   localparam int NCHUNK = mp_nchunk(WIDTH, CHUNK);
   localparam int PW     = NCHUNK * CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   mp_state_t        state_q, state_d;
   logic [WIDTH-1:0] sum_q, carry_q, m_q;
   logic [WIDTH-1:0] res_data_q;
   logic             res_borrow_q;
   logic [PW-1:0]    r_q, d_q;
   logic [IW-1:0]    idx_q;
   logic             cin_q, sub_q;

   logic [WIDTH-1:0] s_n, c_n;
   logic [PW-1:0]    sum_pad, carry_pad, m_pad;
   logic [PW-1:0]    r_next, r_rot, d_next;
   logic [CHUNK-1:0] add_a, add_b, add_s;
   logic             add_inv, add_co;
   int unsigned      base;
   logic             last_chunk;

   // Per-bit 3:2 compressors for the single-cycle accumulate.
   for (genvar i = 0; i < WIDTH; i++) begin : g_csa
      assign s_n[i] = sum_q[i] ^ carry_q[i] ^ in_a[i];
      assign c_n[i] = (sum_q[i] & carry_q[i]) | (sum_q[i] & in_a[i]) | (carry_q[i] & in_a[i]);
   end

   assign sum_pad    = PW'(sum_q);
   assign carry_pad  = PW'(carry_q);
   assign m_pad      = PW'(m_q);
   assign last_chunk = (idx_q == LAST);

   always_comb begin
      base    = int'(idx_q) * CHUNK;
      add_a   = sum_pad[base +: CHUNK];
      add_b   = carry_pad[base +: CHUNK];
      add_inv = 1'b0;
      if (state_q == ST_SUB) begin
         add_a   = r_q[CHUNK-1:0];
         add_b   = m_pad[base +: CHUNK];
         add_inv = 1'b1;
      end
   end

   mp_chunk_adder #(.W(CHUNK)) u_chunk_adder (
      .a     (add_a),
      .b     (add_b),
      .cin   (cin_q),
      .inv_b (add_inv),
      .s     (add_s),
      .cout  (add_co)
   );

   // Results enter at the top and shift down, so after NCHUNK steps chunk 0 sits at bit 0.
   // During SUB, R rotates through itself and is intact again after the last step.
   assign r_next = (r_q >> CHUNK) | (PW'(add_s) << (PW - CHUNK));
   assign r_rot  = (r_q >> CHUNK) | (PW'(r_q[CHUNK-1:0]) << (PW - CHUNK));
   assign d_next = (d_q >> CHUNK) | (PW'(add_s) << (PW - CHUNK));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_valid && cmd_op[1]) state_d = ST_RES;
         ST_RES:  if (last_chunk) state_d = sub_q ? ST_SUB : ST_DONE;
         ST_SUB:  if (last_chunk) state_d = ST_DONE;
         ST_DONE: if (res_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      res_valid = (state_q == ST_DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sum_q        <= '0;
         carry_q      <= '0;
         m_q          <= '0;
         res_data_q   <= '0;
         res_borrow_q <= 1'b0;
         r_q          <= '0;
         d_q          <= '0;
         idx_q        <= '0;
         cin_q        <= 1'b0;
         sub_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op)
                     MP_OP_ACC: begin
                        sum_q   <= s_n;
                        carry_q <= {c_n[WIDTH-2:0], 1'b0};
                     end
                     MP_OP_ACC_SHR: begin
                        sum_q   <= {1'b0, s_n[WIDTH-1:1]};
                        carry_q <= c_n;
                     end
                     default: begin
                        idx_q <= '0;
                        cin_q <= 1'b0;
                        sub_q <= (cmd_op == MP_OP_RESOLVE_SUB);
                        m_q   <= in_a;
                     end
                  endcase
               end
            end
            ST_RES: begin
               r_q   <= r_next;
               cin_q <= add_co;
               idx_q <= idx_q + IW'(1);
               if (last_chunk) begin
                  idx_q <= '0;
                  if (sub_q) begin
                     cin_q <= 1'b1;
                  end else begin
                     res_data_q   <= r_next[WIDTH-1:0];
                     res_borrow_q <= 1'b0;
                     sum_q        <= r_next[WIDTH-1:0];
                     carry_q      <= '0;
                  end
               end
            end
            ST_SUB: begin
               r_q   <= r_rot;
               d_q   <= d_next;
               cin_q <= add_co;
               idx_q <= idx_q + IW'(1);
               if (last_chunk) begin
                  // Carry out of R + ~M + 1 is set exactly when R >= M.
                  idx_q        <= '0;
                  res_borrow_q <= ~add_co;
                  res_data_q   <= add_co ? d_next[WIDTH-1:0] : r_rot[WIDTH-1:0];
                  sum_q        <= add_co ? d_next[WIDTH-1:0] : r_rot[WIDTH-1:0];
                  carry_q      <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign res_data   = res_data_q;
   assign res_borrow = res_borrow_q;
   assign lsb        = sum_q[0] ^ carry_q[0];

endmodule

// File: tb/tb_mp_csa_accumulator.sv
// Directed and bounded-random checks of mp_csa_accumulator at WIDTH=16, CHUNK=5 (NCHUNK=4).
module tb_mp_csa_accumulator;

   localparam logic [1:0] OP_ACC  = 2'b00;
   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_RES  = 2'b10;
   localparam logic [1:0] OP_RSUB = 2'b11;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [15:0] in_a = 16'h0000;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic        res_borrow;
   logic        lsb;

   int n_chk  = 0;
   int n_pass = 0;

   mp_csa_accumulator #(.WIDTH(16), .CHUNK(5)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .in_a       (in_a),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_borrow (res_borrow),
      .lsb        (lsb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // One ACC/ACC_SHR per call; consecutive calls issue on consecutive cycles.
   task automatic acc(input logic [1:0] op, input logic [15:0] a);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      in_a      = a;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      in_a      = 16'hA5A5;
   endtask

   task automatic resolve(input logic [1:0] op, input logic [15:0] m, input logic [15:0] exp_d,
                          input logic exp_b, input int exp_lat, input string tag, input bit hs);
      int edges;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      in_a      = m;
      @(posedge clk);
      edges = 1;
      #1;
      cmd_valid = 1'b0;
      in_a      = 16'h5A5A;
      while (!res_valid && edges < 40) begin
         @(posedge clk);
         edges++;
         #1;
      end
      chk({tag, "_lat"}, 32'(edges), 32'(exp_lat));
      chk({tag, "_data"}, 32'(res_data), 32'(exp_d));
      chk({tag, "_borrow"}, 32'(res_borrow), 32'(exp_b));
      if (hs) begin
         @(negedge clk);
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         chk({tag, "_rdy_after"}, 32'(cmd_ready), 32'd1);
      end
   endtask

   initial begin
      logic [15:0] v;
      logic [15:0] a;
      int          sel;

      // Reset state
      #2;
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_lsb", 32'(lsb), 32'd0);
      chk("rst_data", 32'(res_data), 32'd0);
      chk("rst_borrow", 32'(res_borrow), 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Basic accumulate and resolve
      acc(OP_ACC, 16'h1234);
      acc(OP_ACC, 16'h0F0F);
      chk("acc_lsb", 32'(lsb), 32'd1);
      resolve(OP_RES, 16'h0000, 16'h2143, 1'b0, 5, "res1", 1'b1);

      // Wraparound mod 2^16, then continue on the resolved value
      do_reset();
      acc(OP_ACC, 16'hFFFF);
      acc(OP_ACC, 16'hFFFF);
      resolve(OP_RES, 16'h0000, 16'hFFFE, 1'b0, 5, "wrap", 1'b1);
      acc(OP_ACC, 16'h0001);
      resolve(OP_RES, 16'h0000, 16'hFFFF, 1'b0, 5, "cont", 1'b1);

      // Halving accumulate
      do_reset();
      acc(OP_ACC, 16'h0006);
      acc(OP_SHR, 16'h0004);
      chk("shr_lsb", 32'(lsb), 32'd1);
      resolve(OP_RES, 16'h0000, 16'h0005, 1'b0, 5, "shr", 1'b1);

      // Conditional subtraction: R > M, R < M, R == M
      do_reset();
      acc(OP_ACC, 16'h0025);
      resolve(OP_RSUB, 16'h0010, 16'h0015, 1'b0, 9, "sub_gt", 1'b1);
      do_reset();
      acc(OP_ACC, 16'h000F);
      resolve(OP_RSUB, 16'h0010, 16'h000F, 1'b1, 9, "sub_lt", 1'b1);
      do_reset();
      acc(OP_ACC, 16'h0010);
      resolve(OP_RSUB, 16'h0010, 16'h0000, 1'b0, 9, "sub_eq", 1'b1);
      acc(OP_ACC, 16'h0003);
      resolve(OP_RSUB, 16'hFFFF, 16'h0003, 1'b1, 9, "sub_big", 1'b1);

      // DONE holds while res_ready is low; commands are refused
      do_reset();
      acc(OP_ACC, 16'h0042);
      resolve(OP_RES, 16'h0000, 16'h0042, 1'b0, 5, "hold", 1'b0);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_ACC;
      in_a      = 16'h0001;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_data", 32'(res_data), 32'h0042);
         chk("hold_ready", 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("hold_ret_ready", 32'(cmd_ready), 32'd1);
      chk("hold_ret_valid", 32'(res_valid), 32'd0);
      resolve(OP_RES, 16'h0000, 16'h0042, 1'b0, 5, "hold_after", 1'b1);

      // Reset asserted mid-resolve takes effect without a clock
      do_reset();
      acc(OP_ACC, 16'h1111);
      chk("mid_lsb_pre", 32'(lsb), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_RES;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_busy", 32'(cmd_ready), 32'd0);
      resetn = 1'b0;
      #1;
      chk("mid_valid", 32'(res_valid), 32'd0);
      chk("mid_ready", 32'(cmd_ready), 32'd1);
      chk("mid_lsb", 32'(lsb), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      resolve(OP_RES, 16'h0000, 16'h0000, 1'b0, 5, "mid_after", 1'b1);

      // Bounded random sequences; totals kept below 2^15 so the pair never wraps
      do_reset();
      v = 16'h0000;
      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(0, 4);
         if (v > 16'h7000) sel = 4;
         if (sel < 4) begin
            a = 16'($urandom_range(0, 32'h7FFE - 32'(v)));
            if (sel >= 2) begin
               if (((v + a) & 16'h0001) != 16'h0000) a = a ^ 16'h0001;
               acc(OP_SHR, a);
               v = (v + a) >> 1;
            end else begin
               acc(OP_ACC, a);
               v = v + a;
            end
            chk("rnd_lsb", 32'(lsb), 32'(v[0]));
         end else begin
            resolve(OP_RES, 16'h0000, v, 1'b0, 5, "rnd", 1'b1);
         end
      end
      resolve(OP_RES, 16'h0000, v, 1'b0, 5, "rnd_final", 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
